// File: rtl/tournament_branch_predictor.sv
// Tournament direction predictor: bimodal + gshare tables with a per-PC chooser,
// speculative global history, a 2-stage commit update and a self-clearing init sweep.
module tournament_branch_predictor #(
  parameter int          ADDR_W   = 32,
  parameter int          IDX_W    = 10,
  parameter int          GHR_LEN  = 10,
  parameter logic [1:0]  CTR_INIT = 2'd1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               init_done,
  input  logic               pred_req,
  input  logic [ADDR_W-1:0]  pred_pc,
  input  logic               pred_stall,
  output logic               pred_valid,
  output logic               pred_taken,
  output logic [GHR_LEN-1:0] pred_ghr,
  input  logic               upd_valid,
  input  logic [ADDR_W-1:0]  upd_pc,
  input  logic [GHR_LEN-1:0] upd_ghr,
  input  logic               upd_taken,
  input  logic               upd_mispred
);
  localparam int ENTRIES = 1 << IDX_W;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   cnt;
  logic [GHR_LEN-1:0] ghr;
  logic               running;

  logic [1:0] bim_tbl [ENTRIES];
  logic [1:0] gsh_tbl [ENTRIES];
  logic [1:0] cho_tbl [ENTRIES];

  logic             u2_valid;
  logic [IDX_W-1:0] u2_b_idx, u2_g_idx;
  logic [1:0]       u2_b_val, u2_g_val, u2_c_val;

  function automatic logic [GHR_LEN-1:0] shift_in(input logic [GHR_LEN-1:0] h, input logic b);
    return GHR_LEN'({h, b});
  endfunction

  function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'd3) ? c : c + 2'd1;
    else    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == ST_INIT) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    if (state == ST_INIT && cnt == {IDX_W{1'b1}}) state_next = ST_RUN;
  end

  assign running   = (state == ST_RUN);
  assign init_done = running;

  // pred_valid qualifies pred_taken/pred_ghr; a stall freezes all three and the GHR shift.
  logic [IDX_W-1:0] p_b_idx, p_g_idx;
  logic             pred_fire;
  assign p_b_idx   = pred_pc[IDX_W+1:2];
  assign p_g_idx   = p_b_idx ^ IDX_W'(ghr);
  assign pred_fire = running & pred_req & ~pred_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
      pred_ghr   <= '0;
    end else if (!pred_stall) begin
      pred_valid <= pred_fire;
      if (pred_fire) begin
        pred_taken <= cho_tbl[p_b_idx][1] ? gsh_tbl[p_g_idx][1] : bim_tbl[p_b_idx][1];
        pred_ghr   <= ghr;
      end
    end
  end

  logic upd_fire;
  assign upd_fire = running & upd_valid;

  // Commit-time recovery wins over the speculative shift in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         ghr <= '0;
    else if (upd_fire && upd_mispred)   ghr <= shift_in(upd_ghr, upd_taken);
    else if (pred_valid && !pred_stall) ghr <= shift_in(ghr, pred_taken);
  end

  // U1: read with forwarding from the U2 write so back-to-back updates accumulate.
  logic [IDX_W-1:0] u_b_idx, u_g_idx;
  logic [1:0]       u_b_cur, u_g_cur, u_c_cur, u_b_new, u_g_new, u_c_new;
  assign u_b_idx = upd_pc[IDX_W+1:2];
  assign u_g_idx = u_b_idx ^ IDX_W'(upd_ghr);

  always_comb begin
    u_b_cur = bim_tbl[u_b_idx];
    u_g_cur = gsh_tbl[u_g_idx];
    u_c_cur = cho_tbl[u_b_idx];
    if (u2_valid && u2_b_idx == u_b_idx) begin
      u_b_cur = u2_b_val;
      u_c_cur = u2_c_val;
    end
    if (u2_valid && u2_g_idx == u_g_idx) u_g_cur = u2_g_val;
    u_b_new = sat_step(u_b_cur, upd_taken);
    u_g_new = sat_step(u_g_cur, upd_taken);
    u_c_new = u_c_cur;
    if (u_b_cur[1] != u_g_cur[1]) u_c_new = sat_step(u_c_cur, u_g_cur[1] == upd_taken);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u2_valid <= 1'b0;
      u2_b_idx <= '0;
      u2_g_idx <= '0;
      u2_b_val <= '0;
      u2_g_val <= '0;
      u2_c_val <= '0;
    end else begin
      u2_valid <= upd_fire;
      if (upd_fire) begin
        u2_b_idx <= u_b_idx;
        u2_g_idx <= u_g_idx;
        u2_b_val <= u_b_new;
        u2_g_val <= u_g_new;
        u2_c_val <= u_c_new;
      end
    end
  end

  // Tables carry no reset; the INIT sweep clears them one entry per cycle.
  always_ff @(posedge clk) begin
    if (!running) begin
      bim_tbl[cnt] <= CTR_INIT;
      gsh_tbl[cnt] <= CTR_INIT;
      cho_tbl[cnt] <= CTR_INIT;
    end else if (u2_valid) begin
      bim_tbl[u2_b_idx] <= u2_b_val;
      gsh_tbl[u2_g_idx] <= u2_g_val;
      cho_tbl[u2_b_idx] <= u2_c_val;
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[ADDR_W-1:IDX_W+2], pred_pc[1:0],
                            upd_pc[ADDR_W-1:IDX_W+2], upd_pc[1:0]};

endmodule

// File: tb/tb_tournament_branch_predictor.sv
// Bench for tournament_branch_predictor: table-level reference model plus directed literal checks.
module tb_tournament_branch_predictor;
  localparam int ADDR_W  = 32;
  localparam int IDX_W   = 10;
  localparam int GHR_LEN = 10;
  localparam int ENTRIES = 1 << IDX_W;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               init_done;
  logic               pred_req = 1'b0;
  logic [ADDR_W-1:0]  pred_pc = '0;
  logic               pred_stall = 1'b0;
  logic               pred_valid;
  logic               pred_taken;
  logic [GHR_LEN-1:0] pred_ghr;
  logic               upd_valid = 1'b0;
  logic [ADDR_W-1:0]  upd_pc = '0;
  logic [GHR_LEN-1:0] upd_ghr = '0;
  logic               upd_taken = 1'b0;
  logic               upd_mispred = 1'b0;

  tournament_branch_predictor #(.ADDR_W(ADDR_W), .IDX_W(IDX_W), .GHR_LEN(GHR_LEN), .CTR_INIT(2'd1)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .pred_req(pred_req), .pred_pc(pred_pc), .pred_stall(pred_stall),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
    .upd_taken(upd_taken), .upd_mispred(upd_mispred)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int tbl; int idx; int val; } wr_t;
  wr_t pend_q[$];
  int  arch [3][ENTRIES];   // 0 bimodal, 1 gshare, 2 chooser: committed values
  int  vis  [3][ENTRIES];   // values visible to prediction reads
  bit  m_run, m_valid, m_taken;
  int  m_cnt;
  logic [GHR_LEN-1:0] m_ghr, m_pghr;

  function automatic int sat(input int c, input bit up);
    if (up) return (c == 3) ? 3 : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  function automatic logic [GHR_LEN-1:0] hist(input logic [GHR_LEN-1:0] h, input bit b);
    return {h[GHR_LEN-2:0], b};
  endfunction

  task automatic model_reset();
    m_run = 0; m_valid = 0; m_taken = 0; m_cnt = 0; m_ghr = '0; m_pghr = '0;
    pend_q.delete();
    for (int t = 0; t < 3; t++)
      for (int i = 0; i < ENTRIES; i++) begin
        arch[t][i] = 1;
        vis[t][i]  = 1;
      end
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    bit nv, nt;
    logic [GHR_LEN-1:0] ng, npg;
    int bi, gi, b, g, c;
    wr_t w;
    if (!rst_n) model_reset();
    else if (!m_run) begin
      m_cnt++;
      if (m_cnt == ENTRIES) m_run = 1;
    end else begin
      nv = m_valid; nt = m_taken; npg = m_pghr; ng = m_ghr;
      if (!pred_stall) begin
        nv = pred_req;
        if (pred_req) begin
          bi  = int'(pred_pc[IDX_W+1:2]);
          gi  = bi ^ int'(m_ghr);
          nt  = (vis[2][bi] >= 2) ? (vis[1][gi] >= 2) : (vis[0][bi] >= 2);
          npg = m_ghr;
        end
      end
      if (upd_valid && upd_mispred) ng = hist(upd_ghr, upd_taken);
      else if (m_valid && !pred_stall) ng = hist(m_ghr, m_taken);
      while (pend_q.size() > 0) begin
        w = pend_q.pop_front();
        vis[w.tbl][w.idx] = w.val;
      end
      if (upd_valid) begin
        bi = int'(upd_pc[IDX_W+1:2]);
        gi = bi ^ int'(upd_ghr);
        b = arch[0][bi]; g = arch[1][gi]; c = arch[2][bi];
        if ((b >= 2) != (g >= 2)) c = sat(c, (g >= 2) == upd_taken);
        b = sat(b, upd_taken);
        g = sat(g, upd_taken);
        arch[0][bi] = b; arch[1][gi] = g; arch[2][bi] = c;
        pend_q.push_back('{0, bi, b});
        pend_q.push_back('{1, gi, g});
        pend_q.push_back('{2, bi, c});
      end
      m_valid = nv; m_taken = nt; m_pghr = npg; m_ghr = ng;
    end
  end

  // One compare process: outputs against the model on every settled cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      check("init_done", init_done, m_run);
      check("pred_valid", pred_valid, m_valid);
      if (m_valid) begin
        check("pred_taken", pred_taken, m_taken);
        check("pred_ghr", pred_ghr, m_pghr);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit req, input logic [31:0] pc, input bit stall,
                       input bit uv, input logic [31:0] upc, input logic [GHR_LEN-1:0] ughr,
                       input bit ut, input bit um);
    pred_req = req; pred_pc = pc; pred_stall = stall;
    upd_valid = uv; upd_pc = upc; upd_ghr = ughr; upd_taken = ut; upd_mispred = um;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic predict(input logic [31:0] pc);
    drive(1, pc, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic update(input logic [31:0] pc, input logic [GHR_LEN-1:0] gh, input bit t, input bit mis);
    drive(0, 0, 0, 1, pc, gh, t, mis);
  endtask

  // Counts cycles from reset release (on a falling edge) until init_done rises.
  task automatic wait_init(input string name);
    int n = 0;
    while (!init_done && n < 3000) begin
      @(negedge clk);
      n++;
      if (!init_done) check({name, "_pv"}, pred_valid, 0);
    end
    check(name, n, ENTRIES);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit p, actual;
    logic [GHR_LEN-1:0] g;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    pred_req = 1'b1; pred_pc = 32'h100;
    rst_n = 1'b1;

    // Init sweep, requests ignored during it, first prediction from cleared tables.
    wait_init("init_len");
    predict(32'h100);
    check("t1_valid", pred_valid, 1);
    check("t1_taken", pred_taken, 0);
    check("t1_ghr", pred_ghr, 0);

    // Saturation without wrap and back-to-back update accumulation at pc 0x100.
    repeat (5) update(32'h100, '0, 1, 0);
    idle(2);
    predict(32'h100);
    check("t2_sat_taken", pred_taken, 1);
    check("t2_sat_ghr", pred_ghr, 0);
    update(32'h100, '0, 0, 0);
    idle(2);
    predict(32'h100);
    check("t2_nowrap_taken", pred_taken, 1);
    check("t2_nowrap_ghr", pred_ghr, 10'h001);
    update(32'h100, '0, 0, 0);
    update(32'h100, '0, 0, 0);
    update(32'h100, '0, 1, 0);
    idle(2);
    predict(32'h100);
    check("t2_b2b_taken", pred_taken, 0);
    check("t2_b2b_ghr", pred_ghr, 10'h003);

    // Mispredict recovery, including one coinciding with a valid prediction.
    update(32'h400, 10'h0AA, 1, 1);
    predict(32'h200);
    check("t4_ghr_155", pred_ghr, 10'h155);
    update(32'h400, 10'h0F0, 1, 1);
    predict(32'h200);
    check("t4_ghr_1e1", pred_ghr, 10'h1E1);

    // Stall holds outputs and GHR; release shifts the GHR once.
    update(32'h400, 10'h000, 1, 1);
    predict(32'h200);
    check("t5_valid", pred_valid, 1);
    check("t5_taken", pred_taken, 0);
    check("t5_ghr", pred_ghr, 10'h001);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h104, 1, 0, 0, '0, 0, 0);
      check("t5_stall_valid", pred_valid, 1);
      check("t5_stall_taken", pred_taken, 0);
      check("t5_stall_ghr", pred_ghr, 10'h001);
    end
    idle(1);
    predict(32'h200);
    check("t5_after_ghr", pred_ghr, 10'h002);

    // Alternating branch trained through real checkpoints; gshare must take over.
    for (int k = 0; k < 72; k++) begin
      predict(32'h300);
      p = pred_taken;
      g = pred_ghr;
      actual = (k % 2 == 0);
      if (k >= 64) check("t3_alt_pred", p, actual);
      update(32'h300, g, actual, p != actual);
    end

    // Random traffic over a small PC/history set so forwarding and aliasing get hit.
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 1) == 1, 32'h1000 + 4 * $urandom_range(0, 7),
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            32'h1000 + 4 * $urandom_range(0, 7), GHR_LEN'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);

    // Reset during a pending update write, then again in the middle of the init sweep.
    predict(32'h100);
    pred_req = 1'b1; upd_valid = 1'b1; upd_pc = 32'h100; upd_ghr = '0; upd_taken = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_init_done", init_done, 0);
    check("t6_pred_valid", pred_valid, 0);
    check("t6_pred_taken", pred_taken, 0);
    check("t6_pred_ghr", pred_ghr, 0);
    @(negedge clk);
    pred_req = 1'b0; upd_valid = 1'b0; pred_stall = 1'b0; upd_mispred = 1'b0;
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("t6_mid_init", init_done, 0);
    #1 rst_n = 1'b0;
    #1 check("t6_mid_pred_valid", pred_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("reinit_len");
    predict(32'h100);
    check("t6_post_taken", pred_taken, 0);
    check("t6_post_ghr", pred_ghr, 0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
